// File: rtl/sort_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sort_pkg
// Description : Shared types and default sizing for the sequential
//               odd-even transposition sorter.
//               - state_e    : controller state encoding
//               - elem_arr_t : packed element array at the default sizing,
//                              same layout as the odd_even_sort ports
// Revision    : 1.0 - initial release
// ============================================================================
package sort_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_DATA_N = 7;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        SORT  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    typedef logic [DEF_DATA_N-1:0][DEF_DATA_W-1:0] elem_arr_t;

endpackage
`default_nettype wire

// File: rtl/oe_phase.sv
`default_nettype none
// ============================================================================
// Module      : oe_phase
// Description : One compare-exchange phase of an odd-even transposition
//               sort (purely combinational).
// Ports       : data_in  [DATA_N][DATA_W] - current buffer
//               odd                       - 0: pairs (0,1),(2,3)..
//                                           1: pairs (1,2),(3,4)..
//               desc                      - 0: ascending, 1: descending
//               data_out [DATA_N][DATA_W] - buffer after this phase
//               any_swap                  - at least one pair exchanged
// Revision    : 1.0 - initial release
// ============================================================================
module oe_phase
    import sort_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DATA_N = DEF_DATA_N
) (
    input  logic [DATA_N-1:0][DATA_W-1:0] data_in,
    input  logic                          odd,
    input  logic                          desc,
    output logic [DATA_N-1:0][DATA_W-1:0] data_out,
    output logic                          any_swap
);

    // w_swap[i] means the pair (i, i+1) is active in this phase and out of
    // order; equal values never swap, which keeps the sort stable.
    logic [DATA_N-2:0] w_swap;

    for (genvar i = 0; i < DATA_N - 1; i++) begin : g_cmp
        localparam bit c_pair_odd = ((i % 2) == 1);
        assign w_swap[i] = (odd == c_pair_odd) &&
                           (desc ? (data_in[i] < data_in[i+1])
                                 : (data_in[i] > data_in[i+1]));
    end

    // Active pairs never overlap, so each element is moved by at most one
    // of its two neighbouring comparators. An element not covered by any
    // active pair (the odd-length end element) passes straight through.
    for (genvar j = 0; j < DATA_N; j++) begin : g_out
        if (j == 0) begin : g_first
            assign data_out[j] = w_swap[0] ? data_in[1] : data_in[0];
        end else if (j == DATA_N - 1) begin : g_last
            assign data_out[j] = w_swap[j-1] ? data_in[j-1] : data_in[j];
        end else begin : g_mid
            assign data_out[j] = w_swap[j]   ? data_in[j+1] :
                                 w_swap[j-1] ? data_in[j-1] : data_in[j];
        end
    end

    assign any_swap = |w_swap;

endmodule
`default_nettype wire

// File: rtl/sort_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sort_seq_ctrl
// Description : Iterative odd-even transposition sorter. Loads DATA_N words
//               serially, runs one compare-exchange phase per clock over an
//               internal buffer, then streams the sorted words out.
// Ports       : clk, rst_n           - clock, async active-low reset
//               in_valid/in_ready    - input beat handshake
//               in_data              - input element
//               cfg_desc             - order (0 asc, 1 desc), taken on beat 0
//               out_valid/out_ready  - output beat handshake
//               out_data             - sorted element (0 when not valid)
//               out_last             - final element of the frame
//               busy                 - sorting or draining
//               phases               - phases run by the most recent sort
// Revision    : 1.0 - initial release
// ============================================================================
module sort_seq_ctrl
    import sort_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int DATA_N     = DEF_DATA_N,
    parameter int EARLY_EXIT = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DATA_W-1:0]           in_data,
    input  logic                        cfg_desc,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_W-1:0]           out_data,
    output logic                        out_last,
    output logic                        busy,
    output logic [$clog2(DATA_N+1)-1:0] phases
);

    localparam int PH_W  = $clog2(DATA_N + 1);
    localparam int IDX_W = (DATA_N > 2) ? $clog2(DATA_N) : 1;

    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(DATA_N - 1);
    localparam logic [PH_W-1:0]  c_ph_max   = PH_W'(DATA_N);

    state_e                        r_state;
    state_e                        w_next_state;
    logic [IDX_W-1:0]              r_wr_idx;
    logic [IDX_W-1:0]              r_rd_idx;
    logic [PH_W-1:0]               r_phase_cnt;
    logic [PH_W-1:0]               r_phases;
    logic                          r_odd;
    logic [1:0]                    r_zero_run;
    logic                          r_desc;
    logic [DATA_N-1:0][DATA_W-1:0] r_mem;

    logic [DATA_N-1:0][DATA_W-1:0] w_mem_next;
    logic                          w_any_swap;
    logic [PH_W-1:0]               w_ph_next;
    logic [1:0]                    w_zr_next;
    logic                          w_sort_done;

    oe_phase #(
        .DATA_W (DATA_W),
        .DATA_N (DATA_N)
    ) u_oe_phase (
        .data_in  (r_mem),
        .odd      (r_odd),
        .desc     (r_desc),
        .data_out (w_mem_next),
        .any_swap (w_any_swap)
    );

    // Two back-to-back quiet phases (one even, one odd) prove every
    // adjacent pair is already in order, so the buffer is final.
    assign w_ph_next = r_phase_cnt + 1'b1;
    assign w_zr_next = w_any_swap          ? 2'd0 :
                       (r_zero_run == 2'd3) ? 2'd3 : r_zero_run + 2'd1;
    assign w_sort_done = (w_ph_next == c_ph_max) ||
                         ((EARLY_EXIT != 0) && (w_zr_next == 2'd2));

    assign phases = r_phases;

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= LOAD;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        out_data     = '0;
        out_last     = 1'b0;
        busy         = 1'b0;
        case (r_state)
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid && (r_wr_idx == c_last_idx)) begin
                    w_next_state = SORT;
                end
            end
            SORT: begin
                busy = 1'b1;
                if (w_sort_done) begin
                    w_next_state = DRAIN;
                end
            end
            DRAIN: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_data  = r_mem[r_rd_idx];
                out_last  = (r_rd_idx == c_last_idx);
                if (out_ready && (r_rd_idx == c_last_idx)) begin
                    w_next_state = LOAD;
                end
            end
            default: begin
                w_next_state = LOAD;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Counters, sort order and phase bookkeeping
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_idx    <= '0;
            r_rd_idx    <= '0;
            r_phase_cnt <= '0;
            r_phases    <= '0;
            r_odd       <= 1'b0;
            r_zero_run  <= 2'd0;
            r_desc      <= 1'b0;
        end else begin
            case (r_state)
                LOAD: begin
                    if (in_valid) begin
                        if (r_wr_idx == '0) begin
                            r_desc <= cfg_desc;
                        end
                        if (r_wr_idx == c_last_idx) begin
                            r_wr_idx    <= '0;
                            r_phase_cnt <= '0;
                            r_odd       <= 1'b0;
                            r_zero_run  <= 2'd0;
                        end else begin
                            r_wr_idx <= r_wr_idx + 1'b1;
                        end
                    end
                end
                SORT: begin
                    r_phase_cnt <= w_ph_next;
                    r_odd       <= ~r_odd;
                    r_zero_run  <= w_zr_next;
                    if (w_sort_done) begin
                        r_phases <= w_ph_next;
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        if (r_rd_idx == c_last_idx) begin
                            r_rd_idx <= '0;
                            r_wr_idx <= '0;
                        end else begin
                            r_rd_idx <= r_rd_idx + 1'b1;
                        end
                    end
                end
                default: begin
                    r_wr_idx <= '0;
                    r_rd_idx <= '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Element buffer: no reset needed, every frame rewrites all entries
    // before any of them is read.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if ((r_state == LOAD) && in_valid) begin
            r_mem[r_wr_idx] <= in_data;
        end else if (r_state == SORT) begin
            r_mem <= w_mem_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sort_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sort_seq_ctrl
// Description : Self-checking bench for sort_seq_ctrl. Expected outputs come
//               from a queue sort; expected phase counts from replaying the
//               odd-even transposition rules on a plain integer array.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sort_seq_ctrl;

    localparam int N = 7;
    localparam int W = 8;

    typedef logic [W-1:0] frame_t [N];

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_ready, cfg_desc;
    logic [W-1:0] in_data;
    logic         out_valid, out_ready, out_last, busy;
    logic [W-1:0] out_data;
    logic [2:0]   phases;

    logic         nx_in_valid, nx_in_ready, nx_out_valid, nx_out_last, nx_busy;
    logic [W-1:0] nx_in_data, nx_out_data;
    logic [2:0]   nx_phases;

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    bit pat[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    always #5 clk = ~clk;

    sort_seq_ctrl #(.DATA_W(W), .DATA_N(N), .EARLY_EXIT(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .cfg_desc(cfg_desc),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy), .phases(phases)
    );

    sort_seq_ctrl #(.DATA_W(W), .DATA_N(N), .EARLY_EXIT(0)) dut_nx (
        .clk(clk), .rst_n(rst_n),
        .in_valid(nx_in_valid), .in_ready(nx_in_ready), .in_data(nx_in_data),
        .cfg_desc(1'b0),
        .out_valid(nx_out_valid), .out_ready(1'b1), .out_data(nx_out_data),
        .out_last(nx_out_last), .busy(nx_busy), .phases(nx_phases)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Reference: replay phases on an integer array to count them.
    function automatic int model_phases(input frame_t v, input bit desc, input bit early);
        int a [N];
        int zr, ph, t;
        bit sw, stop;
        for (int i = 0; i < N; i++) a[i] = int'(v[i]);
        zr = 0; ph = 0; stop = 0;
        for (int p = 0; p < N; p++) begin
            if (!stop) begin
                sw = 0;
                for (int i = p % 2; i + 1 < N; i += 2) begin
                    if (desc ? (a[i] < a[i+1]) : (a[i] > a[i+1])) begin
                        t = a[i]; a[i] = a[i+1]; a[i+1] = t; sw = 1;
                    end
                end
                ph = p + 1;
                zr = sw ? 0 : zr + 1;
                if (early && zr == 2) stop = 1;
            end
        end
        return ph;
    endfunction

    task automatic send_frame(input frame_t v, input bit desc, input bit gaps,
                              input bit toggle, input bit hold);
        for (int i = 0; i < N; i++) begin
            if (gaps) begin
                int g = $urandom_range(0, 2);
                repeat (g) begin
                    @(negedge clk);
                    in_valid = 1'b0;
                    in_data  = W'($urandom);
                end
            end
            @(negedge clk);
            check("in_ready_load", in_ready, 1);
            check("out_data_idle", out_data, 0);
            in_valid = 1'b1;
            in_data  = v[i];
            cfg_desc = (i == 0) ? desc : (toggle ? ~desc : desc);
        end
        @(negedge clk);
        in_valid = hold;
        in_data  = W'($urandom);
        cfg_desc = ~desc;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 3 * N) begin
            check("busy_sort", busy, 1);
            check("in_ready_sort", in_ready, 0);
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic drain(input int mode, input bit hold);
        int idx = 0;
        int cyc = 0;
        while (idx < N && cyc < 20 * N) begin
            if (cyc > 0) @(negedge clk);
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = pat[cyc % 6];
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (hold) in_data = W'($urandom);
            check("out_valid", out_valid, 1);
            check("out_data", out_data, exp_q[idx]);
            check("out_last", out_last, (idx == N - 1));
            check("in_ready_drain", in_ready, 0);
            if (out_ready) idx++;
            cyc++;
        end
        check("drain_done", idx, N);
    endtask

    task automatic run_frame(input frame_t v, input bit desc, input bit gaps,
                             input bit toggle, input bit hold, input int mode);
        int ph, lat;
        ph = model_phases(v, desc, 1'b1);
        exp_q.delete();
        for (int i = 0; i < N; i++) exp_q.push_back(int'(v[i]));
        if (desc) exp_q.rsort(); else exp_q.sort();
        send_frame(v, desc, gaps, toggle, hold);
        wait_out(lat);
        check("latency", lat, ph);
        check("phases", phases, ph);
        drain(mode, hold);
    endtask

    function automatic frame_t rand_frame(input bit narrow);
        frame_t f;
        for (int i = 0; i < N; i++)
            f[i] = narrow ? W'($urandom_range(0, 3)) : W'($urandom);
        return f;
    endfunction

    initial begin
        frame_t v;
        int lat;
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; cfg_desc = 1'b0; out_ready = 1'b1;
        nx_in_valid = 1'b0; nx_in_data = '0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_out_data", out_data, 0);
        check("rst_busy", busy, 0);
        check("rst_phases", phases, 0);
        rst_n = 1'b1;

        // Reverse order, ascending: needs every phase.
        v = '{8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
        run_frame(v, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        check("t1_phases7", phases, 7);

        // Already sorted: early exit after two quiet phases.
        v = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7};
        run_frame(v, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        check("t2_phases2", phases, 2);

        // Same frame without early exit.
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            nx_in_valid = 1'b1;
            nx_in_data  = v[i];
        end
        @(negedge clk);
        nx_in_valid = 1'b0;
        lat = 0;
        while (!nx_out_valid && lat < 3 * N) begin
            @(negedge clk);
            lat++;
        end
        check("nx_latency", lat, model_phases(v, 1'b0, 1'b0));
        check("nx_phases", nx_phases, 7);
        for (int i = 0; i < N; i++) begin
            check("nx_out_data", nx_out_data, i + 1);
            check("nx_out_last", nx_out_last, (i == N - 1));
            @(negedge clk);
        end
        check("nx_idle", nx_out_valid, 0);

        // Descending, cfg_desc toggled on later beats.
        v = '{8'd3, 8'd9, 8'd3, 8'd0, 8'd255, 8'd1, 8'd7};
        run_frame(v, 1'b1, 1'b0, 1'b1, 1'b0, 0);

        // Backpressure pattern with in_valid held high, then a clean frame.
        run_frame(rand_frame(1'b0), 1'b0, 1'b0, 1'b0, 1'b1, 1);
        run_frame(rand_frame(1'b0), 1'b1, 1'b0, 1'b0, 1'b0, 0);

        // Reset during SORT, after three phases.
        v = '{8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
        send_frame(v, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check("busy_pre_rst", busy, 1);
        rst_n = 1'b0;
        #1;
        check("rst_sort_out_valid", out_valid, 0);
        check("rst_sort_in_ready", in_ready, 1);
        check("rst_sort_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        v = '{8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5};
        run_frame(v, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        check("t5_phases2", phases, 2);

        // Reset during DRAIN drops the output at once.
        send_frame(rand_frame(1'b0), 1'b0, 1'b0, 1'b0, 1'b0);
        wait_out(lat);
        out_ready = 1'b0;
        check("pre_rst_drain_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        check("rst_drain_out_valid", out_valid, 0);
        check("rst_drain_out_data", out_data, 0);
        check("rst_drain_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;

        // Back-to-back frames, second one with input gaps.
        v = '{8'd0, 8'd255, 8'd128, 8'd1, 8'd254, 8'd2, 8'd127};
        run_frame(v, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        run_frame(rand_frame(1'b0), 1'b0, 1'b1, 1'b0, 1'b0, 2);

        // Random frames, including many duplicates.
        for (int f = 0; f < 10; f++) begin
            run_frame(rand_frame(1'(f % 2)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 1'b1, 1'b0, 2);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sort_seq_ctrl.md
Name: sort_seq_ctrl

Overview:
- Iterative odd-even transposition sorter with a frame-level stream interface.
- Loads DATA_N words serially, then runs one compare-exchange phase per clock over an internal buffer, then streams the sorted words out.
- Serves as the low-area, multi-cycle companion to the fully unrolled odd_even_sort network, for sites where throughput is not critical.

Parameters:
- DATA_W, 8, element width in bits; compare is unsigned.
- DATA_N, 7, elements per frame; must be >= 2.
- EARLY_EXIT, 1, 1 = stop after two consecutive zero-swap phases; 0 = always run DATA_N phases.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- in_data  in  DATA_W  input element.
- cfg_desc  in  1  sort order: 0 = ascending, 1 = descending; sampled on the first accepted beat of each frame.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accept.
- out_data  out  DATA_W  sorted element; 0 when out_valid = 0.
- out_last  out  1  marks the final element of a frame.
- busy  out  1  high in SORT and DRAIN.
- phases  out  $clog2(DATA_N+1)  phases executed in the most recent sort; holds until the next sort completes.

Behaviour:
- Reset (async, rst_n low): state = LOAD, wr_idx = rd_idx = 0, phases = 0. Outputs: out_valid 0, out_last 0, out_data 0, busy 0, in_ready 1. Buffer contents are don't-care.
- Reset mid-operation in any state: abandon the frame and return to LOAD; no partial output.
- LOAD state:
  - in_ready = 1. Each accepted beat writes buf[wr_idx], then wr_idx increments.
  - cfg_desc is latched on the accept with wr_idx = 0.
  - The accept at wr_idx = DATA_N-1 moves to SORT with phase_cnt = 0, parity = even, zero-run = 0.
- SORT state:
  - in_ready = 0. One phase completes on each rising edge.
  - Even phase compares pairs (0,1),(2,3)...; odd phase compares (1,2),(3,4)...
  - For odd DATA_N, the unpaired end element passes through unchanged.
  - Swap when buf[i] > buf[i+1] (ascending) or buf[i] < buf[i+1] (descending). Equal values never swap.
  - Parity alternates after every phase, and phase_cnt increments.
  - zero-run counts consecutive phases with no swap; any swap resets it to 0.
  - Exit to DRAIN after the phase that makes phase_cnt = DATA_N, or, with EARLY_EXIT = 1, the phase that makes zero-run = 2, whichever comes first.
  - phases is loaded with phase_cnt on exit.
- Ordering: final buf[0] is the smallest element (ascending) or the largest (descending).
- Latency: out_valid rises P edges after the edge that accepted the last input beat, where P = phases. Range is 2..DATA_N with early exit, and exactly DATA_N without.
- DRAIN state:
  - out_valid = 1, out_data = buf[rd_idx], out_last = (rd_idx == DATA_N-1).
  - rd_idx advances on out_valid && out_ready.
  - Backpressure: out_data and out_last stay stable while out_ready = 0.
  - The handshake with out_last moves to LOAD and clears rd_idx and wr_idx.
  - in_valid is ignored throughout SORT and DRAIN.
- Throughput: the next frame's first beat can be accepted in the cycle after the out_last handshake. The minimum frame period is DATA_N + P + DATA_N cycles.

Decomposition:
- Shared package sort_pkg:
  - state_e enum {LOAD, SORT, DRAIN}.
  - Default DATA_W / DATA_N constants.
  - Packed array typedef elem_arr_t as logic [DATA_N-1:0][DATA_W-1:0], matching the odd_even_sort port style.
- Sub-module oe_phase (combinational):
  - Inputs: packed buffer, odd/even select, desc.
  - Outputs: next buffer and any_swap flag.
- sort_seq_ctrl keeps the FSM, the counters, the buffer register and the handshakes.

Test Plan:
1. Ascending, 7,6,5,4,3,2,1, out_ready = 1 -> outputs 1,2,3,4,5,6,7; out_last on 7 only; phases = 7; out_valid 7 edges after the last accept.
2. Already sorted 1..7, ascending, EARLY_EXIT = 1 -> phases = 2; out_valid 2 edges after the last accept; outputs unchanged. Same input with EARLY_EXIT = 0 -> phases = 7.
3. cfg_desc = 1 on beat 0, input 3,9,3,0,255,1,7 (cfg_desc toggled on later beats) -> outputs 255,9,7,3,3,1,0.
4. out_ready pattern 1,0,0,1,0,1... during DRAIN, in_valid held high -> each element held stable until handshake; no drop or duplication; in_ready = 0 until after out_last; the next frame loads correctly afterwards.
5. rst_n pulsed low during SORT (phase 3), then the frame 5,5,5,5,5,5,5 -> out_valid drops immediately and in_ready = 1; the new frame outputs seven 5s with phases = 2.
6. Back-to-back frames, 0,255,128,1,254,2,127 followed by a random frame with in_valid gaps -> first frame outputs 0,1,2,127,128,254,255; both frames sorted with correct out_last, checked against a reference model.
